msg_frame_decoder: RTL and testbench

Parametrised successor to the UART message receiver in the Astrotinker controller. Assembles `rx_complete`-strobed bytes into frames terminated by `TERM_CHAR` and decodes fault (`IFM-xU-#`) and pick-block (`PBM-SU-Bn-#`) messages. Decoded results go out as sticky flags plus a valid/ack result record, with overflow and drop reporting. Sits between the UART receiver and the path-planning/arm control FSMs.

---
 rtl/msg_frame_pkg.sv | 38 +++
 rtl/msg_frame_buffer.sv | 44 ++++
 rtl/msg_frame_decoder.sv | 173 +++++++++++++++++
 tb/tb_msg_frame_decoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_frame_pkg.sv
// Shared character codes, result enums and FSM states for the message frame decoder.
package msg_frame_pkg;

  localparam logic [7:0] CH_I    = 8'h49;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_U    = 8'h55;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_ONE  = 8'h31;

  typedef enum logic [1:0] {
    MT_NONE = 2'd0,
    MT_IFM  = 2'd1,
    MT_PBM  = 2'd2
  } msg_type_t;

  typedef enum logic [1:0] {
    MU_EU = 2'd0,
    MU_CU = 2'd1,
    MU_RU = 2'd2,
    MU_SU = 2'd3
  } msg_unit_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECODE   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DISCARD  = 2'd3
  } state_t;

endpackage

// File: rtl/msg_frame_buffer.sv
// Frame byte store with write index; flags terminator and overflow on the incoming byte.
module msg_frame_buffer
  import msg_frame_pkg::*;
#(
  parameter int          MAX_LEN   = 12,
  parameter logic [7:0]  TERM_CHAR = CH_HASH,
  localparam int         IDX_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic                    idx_clr,
  input  logic [7:0]              wr_byte,
  output logic                    is_term,
  output logic                    term_hit,
  output logic                    ovf_hit,
  output logic [IDX_W-1:0]        idx,
  output logic [MAX_LEN-1:0][7:0] frame_buf
);

  assign is_term  = (wr_byte == TERM_CHAR);
  assign term_hit = wr_en && is_term;
  // Overflow is judged on the current index, before any increment, so idx never wraps.
  assign ovf_hit  = wr_en && !is_term && (idx == IDX_W'(MAX_LEN - 1));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (idx_clr || ovf_hit) begin
      idx <= '0;
    end else if (wr_en && !is_term) begin
      idx <= idx + 1'b1;
    end
  end

  // NOTE: the byte store has no reset; bytes are always written before the decoder reads them.
  always_ff @(posedge clk_50M) begin
    if (wr_en) begin
      frame_buf[idx] <= wr_byte;
    end
  end

endmodule

// File: rtl/msg_frame_decoder.sv
// Assembles UART bytes into frames and decodes IFM fault / PBM pick-block messages.
// Define MSG_FRAME_STRICT_EN to also require the dash separators and exact terminator position.
module msg_frame_decoder
  import msg_frame_pkg::*;
#(
  parameter int         MAX_LEN    = 12,
  parameter logic [7:0] TERM_CHAR  = CH_HASH,
  parameter int         NUM_BLOCKS = 4,
  localparam int        BL_W       = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  localparam int        IDX_W      = $clog2(MAX_LEN + 1)
) (
  input  logic            clk_50M,
  input  logic            rst_n,
  input  logic [7:0]      rx_msg,
  input  logic            rx_complete,
  input  logic [3:0]      flag_clr,
  input  logic            msg_ack,
  output logic            EU_fault_flag,
  output logic            CU_fault_flag,
  output logic            RU_fault_flag,
  output logic            pick_block_flag,
  output logic [BL_W-1:0] block_location,
  output logic            msg_valid,
  output logic [1:0]      msg_type,
  output logic [1:0]      msg_unit,
  output logic            frame_ovf,
  output logic            rx_drop
);

  localparam logic [7:0] CH_LAST = 8'(8'h30 + NUM_BLOCKS);

  state_t                  state, state_next;
  logic                    is_term, term_hit, ovf_hit;
  logic [IDX_W-1:0]        idx;
  logic [MAX_LEN-1:0][7:0] frame_buf;

  // Flags packed as {pick, RU, CU, EU} to line up with flag_clr.
  logic [3:0]      flags_q, flags_next, flags_set;
  logic            valid_next, ovf_next, drop_next;
  msg_type_t       type_q, type_next, dec_type;
  msg_unit_t       unit_q, unit_next, dec_unit;
  logic [BL_W-1:0] loc_next, dec_loc;
  logic [3:0]      dec_set;
  logic            is_ifm, is_pbm, blk_ok, fmt_ok;
  logic            unused_bits;

  msg_frame_buffer #(
    .MAX_LEN   (MAX_LEN),
    .TERM_CHAR (TERM_CHAR)
  ) u_buffer (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .wr_en     (rx_complete && (state == ST_IDLE)),
    .idx_clr   (state == ST_DECODE),
    .wr_byte   (rx_msg),
    .is_term   (is_term),
    .term_hit  (term_hit),
    .ovf_hit   (ovf_hit),
    .idx       (idx),
    .frame_buf (frame_buf)
  );

  assign is_ifm = (frame_buf[0] == CH_I) && (frame_buf[1] == CH_F) && (frame_buf[2] == CH_M);
  assign is_pbm = (frame_buf[0] == CH_P) && (frame_buf[1] == CH_B) && (frame_buf[2] == CH_M) &&
                  (frame_buf[4] == CH_S) && (frame_buf[5] == CH_U) && (frame_buf[7] == CH_B);
  assign blk_ok = (frame_buf[8] >= CH_ONE) && (frame_buf[8] <= CH_LAST);
  assign dec_loc = BL_W'(frame_buf[8] - CH_ONE);

`ifdef MSG_FRAME_STRICT_EN
  assign fmt_ok = (frame_buf[3] == CH_DASH) && (frame_buf[6] == CH_DASH) &&
                  (is_ifm ? (idx == IDX_W'(7))
                          : ((frame_buf[9] == CH_DASH) && (idx == IDX_W'(10))));
`else
  assign fmt_ok = 1'b1;
`endif

  // Buffer bytes past the decoded fields, and idx in the relaxed build, are intentionally unread.
  assign unused_bits = ^{frame_buf, idx};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_type = MT_NONE;
    dec_unit = MU_EU;
    dec_set  = 4'b0000;
    if (is_ifm) begin
      case (frame_buf[4])
        CH_E:    begin dec_type = MT_IFM; dec_unit = MU_EU; dec_set = 4'b0001; end
        CH_C:    begin dec_type = MT_IFM; dec_unit = MU_CU; dec_set = 4'b0010; end
        CH_R:    begin dec_type = MT_IFM; dec_unit = MU_RU; dec_set = 4'b0100; end
        default: dec_type = MT_NONE;
      endcase
    end else if (is_pbm && blk_ok) begin
      dec_type = MT_PBM;
      dec_unit = MU_SU;
      dec_set  = 4'b1000;
    end
    if (!fmt_ok) begin
      dec_type = MT_NONE;
      dec_unit = MU_EU;
      dec_set  = 4'b0000;
    end
  end

  always_comb begin
    state_next = state;
    valid_next = msg_valid;
    type_next  = type_q;
    unit_next  = unit_q;
    loc_next   = block_location;
    ovf_next   = 1'b0;
    drop_next  = 1'b0;
    flags_set  = 4'b0000;
    case (state)
      ST_IDLE: begin
        if (term_hit) begin
          state_next = ST_DECODE;
        end else if (ovf_hit) begin
          ovf_next   = 1'b1;
          state_next = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (rx_complete && is_term) state_next = ST_IDLE;
      end
      ST_DECODE: begin
        drop_next  = rx_complete;
        valid_next = 1'b1;
        type_next  = dec_type;
        unit_next  = dec_unit;
        flags_set  = dec_set;
        if (dec_set[3]) loc_next = dec_loc;
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        drop_next = rx_complete;
        if (msg_ack) begin
          valid_next = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A set in the same cycle as its clear wins.
    flags_next = flags_set | (flags_q & ~flag_clr);
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      flags_q        <= '0;
      block_location <= '0;
      msg_valid      <= 1'b0;
      type_q         <= MT_NONE;
      unit_q         <= MU_EU;
      frame_ovf      <= 1'b0;
      rx_drop        <= 1'b0;
    end else begin
      state          <= state_next;
      flags_q        <= flags_next;
      block_location <= loc_next;
      msg_valid      <= valid_next;
      type_q         <= type_next;
      unit_q         <= unit_next;
      frame_ovf      <= ovf_next;
      rx_drop        <= drop_next;
    end
  end

  assign {pick_block_flag, RU_fault_flag, CU_fault_flag, EU_fault_flag} = flags_q;
  assign msg_type = type_q;
  assign msg_unit = unit_q;

endmodule

// File: tb/tb_msg_frame_decoder.sv
// Self-checking bench: directed frames plus a random byte stream against a frame-level model.
module tb_msg_frame_decoder;

  localparam int         MAX_LEN    = 12;
  localparam logic [7:0] TERM       = 8'h23;
  localparam int         NUM_BLOCKS = 4;

  typedef enum int {P_COLLECT, P_DISCARD, P_PENDING, P_HOLD} phase_t;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_msg = 8'h00;
  logic       rx_complete = 1'b0;
  logic [3:0] flag_clr = 4'h0;
  logic       msg_ack = 1'b0;
  logic       EU_fault_flag, CU_fault_flag, RU_fault_flag, pick_block_flag;
  logic [1:0] block_location;
  logic       msg_valid;
  logic [1:0] msg_type, msg_unit;
  logic       frame_ovf, rx_drop;

  int n_chk = 0;
  int n_err = 0;
  int ovf_seen = 0;

  phase_t     phase = P_COLLECT;
  logic [7:0] mbuf [MAX_LEN];
  int         mlen = 0;
  logic [3:0] e_flags = 4'h0;
  logic       e_valid = 1'b0;
  int         e_type = 0, e_unit = 0, e_loc = 0;
  logic       e_ovf = 1'b0, e_drop = 1'b0;
  logic [7:0] q [$];

  msg_frame_decoder #(
    .MAX_LEN    (MAX_LEN),
    .TERM_CHAR  (TERM),
    .NUM_BLOCKS (NUM_BLOCKS)
  ) dut (
    .clk_50M         (clk_50M),
    .rst_n           (rst_n),
    .rx_msg          (rx_msg),
    .rx_complete     (rx_complete),
    .flag_clr        (flag_clr),
    .msg_ack         (msg_ack),
    .EU_fault_flag   (EU_fault_flag),
    .CU_fault_flag   (CU_fault_flag),
    .RU_fault_flag   (RU_fault_flag),
    .pick_block_flag (pick_block_flag),
    .block_location  (block_location),
    .msg_valid       (msg_valid),
    .msg_type        (msg_type),
    .msg_unit        (msg_unit),
    .frame_ovf       (frame_ovf),
    .rx_drop         (rx_drop)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Frame-level interpretation of the message rules, applied to the bytes the model collected.
  task automatic decode_frame(output logic [3:0] set);
    bit    ifm, pbm, fmt;
    int    d;
    string letters;
    letters = "ECR";
    set     = 4'h0;
    e_type  = 0;
    e_unit  = 0;
    ifm = (mbuf[0] == "I") && (mbuf[1] == "F") && (mbuf[2] == "M");
    pbm = (mbuf[0] == "P") && (mbuf[1] == "B") && (mbuf[2] == "M") &&
          (mbuf[4] == "S") && (mbuf[5] == "U") && (mbuf[7] == "B");
    fmt = 1'b1;
`ifdef MSG_FRAME_STRICT_EN
    fmt = (mbuf[3] == "-") && (mbuf[6] == "-") &&
          (ifm ? (mlen == 7) : ((mbuf[9] == "-") && (mlen == 10)));
`endif
    if (!fmt) return;
    if (ifm) begin
      for (int u = 0; u < 3; u++) begin
        if (mbuf[4] == letters[u]) begin
          e_type = 1;
          e_unit = u;
          set[u] = 1'b1;
        end
      end
    end else if (pbm) begin
      d = int'(mbuf[8]) - 48;
      if (d >= 1 && d <= NUM_BLOCKS) begin
        e_type = 2;
        e_unit = 3;
        e_loc  = d - 1;
        set[3] = 1'b1;
      end
    end
  endtask

  task automatic model_update(input logic rxc, input logic [7:0] b, input logic ack,
                              input logic [3:0] clr, input logic rst);
    logic [3:0] set;
    set    = 4'h0;
    e_ovf  = 1'b0;
    e_drop = 1'b0;
    if (rst) begin
      phase = P_COLLECT; mlen = 0; e_flags = 4'h0; e_valid = 1'b0;
      e_type = 0; e_unit = 0; e_loc = 0;
      return;
    end
    case (phase)
      P_COLLECT: if (rxc) begin
        mbuf[mlen] = b;
        if (b == TERM) phase = P_PENDING;
        else if (mlen == MAX_LEN - 1) begin e_ovf = 1'b1; phase = P_DISCARD; mlen = 0; end
        else mlen++;
      end
      P_DISCARD: if (rxc && b == TERM) phase = P_COLLECT;
      P_PENDING: begin
        e_drop = rxc;
        decode_frame(set);
        e_valid = 1'b1;
        phase   = P_HOLD;
        mlen    = 0;
      end
      P_HOLD: begin
        e_drop = rxc;
        if (ack) begin e_valid = 1'b0; phase = P_COLLECT; end
      end
      default: phase = P_COLLECT;
    endcase
    e_flags = set | (e_flags & ~clr);
  endtask

  task automatic compare_all();
    if (frame_ovf) ovf_seen++;
    check("flags", 32'({pick_block_flag, RU_fault_flag, CU_fault_flag, EU_fault_flag}), 32'(e_flags));
    check("msg_valid", 32'(msg_valid), 32'(e_valid));
    if (e_valid) check("msg_type", 32'(msg_type), 32'(e_type));
    if (e_valid && e_type != 0) check("msg_unit", 32'(msg_unit), 32'(e_unit));
    check("block_location", 32'(block_location), 32'(e_loc));
    check("frame_ovf", 32'(frame_ovf), 32'(e_ovf));
    check("rx_drop", 32'(rx_drop), 32'(e_drop));
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic step(input logic rxc, input logic [7:0] b, input logic ack,
                      input logic [3:0] clr, input logic rst);
    rst_n = !rst; rx_complete = rxc; rx_msg = b; msg_ack = ack; flag_clr = clr;
    @(posedge clk_50M);
    model_update(rxc, b, ack, clr, rst);
    @(negedge clk_50M);
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic ack_step();
    step(1'b0, 8'h00, 1'b1, 4'h0, 1'b0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, 4'h0, 1'b0);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic push_letters(input int n);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(8'h41, 8'h5A)));
  endtask

  task automatic gen_frame();
    string units;
    int    kind;
    units = "ECRS";
    kind  = $urandom_range(0, 5);
    case (kind)
      0, 1: begin
        push_str("IFM");
        q.push_back(($urandom_range(0, 7) == 0) ? 8'h2B : 8'h2D);
        q.push_back(units[$urandom_range(0, 3)]);
        push_str("U-");
        if ($urandom_range(0, 5) == 0) push_letters(1);
        q.push_back(TERM);
      end
      2, 3: begin
        push_str("PBM");
        q.push_back(($urandom_range(0, 7) == 0) ? 8'h2B : 8'h2D);
        push_str("SU-B");
        q.push_back(8'($urandom_range(8'h30, 8'h36)));
        q.push_back(($urandom_range(0, 7) == 0) ? 8'h5F : 8'h2D);
        if ($urandom_range(0, 5) == 0) push_letters(1);
        q.push_back(TERM);
      end
      4: begin
        push_letters($urandom_range(0, 9));
        q.push_back(TERM);
      end
      default: begin
        push_letters(MAX_LEN + $urandom_range(0, 3));
        q.push_back(TERM);
      end
    endcase
  endtask

  initial begin
    logic       rxc;
    logic [7:0] b;
    for (int i = 0; i < MAX_LEN; i++) mbuf[i] = 8'h00;
    @(negedge clk_50M);
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    check("reset_outputs", 32'({EU_fault_flag, CU_fault_flag, RU_fault_flag, pick_block_flag,
                                block_location, msg_valid, msg_type, msg_unit, frame_ovf, rx_drop}), 32'd0);

    // IFM control-unit fault.
    send_str("IFM-CU-#");
    idle();
    check("ifm_cu_flag", 32'(CU_fault_flag), 32'd1);
    check("ifm_cu_type", 32'(msg_type), 32'd1);
    check("ifm_cu_unit", 32'(msg_unit), 32'd1);
    ack_step();
    idle();

    // Pick-block message, then clear its flag.
    send_str("PBM-SU-B3-#");
    idle();
    check("pbm_flag", 32'(pick_block_flag), 32'd1);
    check("pbm_loc", 32'(block_location), 32'd2);
    check("pbm_type", 32'(msg_type), 32'd2);
    check("pbm_unit", 32'(msg_unit), 32'd3);
    ack_step();
    step(1'b0, 8'h00, 1'b0, 4'b1000, 1'b0);
    check("pbm_clear", 32'(pick_block_flag), 32'd0);

    // Overflow: the first terminator only ends the discard.
    ovf_seen = 0;
    send_str("ABCDEFGHIJKLMN");
    send_str("IFM-EU-#");
    idle();
    idle();
    check("ovf_pulses", 32'(ovf_seen), 32'd1);
    check("ovf_eu_clear", 32'(EU_fault_flag), 32'd0);
    send_str("IFM-EU-#");
    idle();
    check("post_ovf_eu", 32'(EU_fault_flag), 32'd1);
    ack_step();

    // Byte dropped while the result waits for its ack.
    send_str("IFM-RU-#");
    idle();
    step(1'b1, "X", 1'b0, 4'h0, 1'b0);
    check("drop_pulse", 32'(rx_drop), 32'd1);
    check("drop_valid_held", 32'(msg_valid), 32'd1);
    ack_step();
    check("ack_clears_valid", 32'(msg_valid), 32'd0);

    // Unknown header, then a separator that only strict mode rejects.
    send_str("XYZ-EU-#");
    idle();
    check("unknown_type", 32'(msg_type), 32'd0);
    ack_step();
    send_str("IFM+EU-#");
    idle();
`ifdef MSG_FRAME_STRICT_EN
    check("bad_sep_type", 32'(msg_type), 32'd0);
`else
    check("bad_sep_type", 32'(msg_type), 32'd1);
`endif
    ack_step();

    // Reset mid-frame, then a clean frame.
    send_str("PBM-S");
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    check("midframe_reset", 32'({EU_fault_flag, CU_fault_flag, RU_fault_flag, pick_block_flag,
                                 block_location, msg_valid, msg_type, msg_unit, frame_ovf, rx_drop}), 32'd0);
    send_str("IFM-EU-#");
    idle();
    check("after_reset_type", 32'(msg_type), 32'd1);
    check("after_reset_eu", 32'(EU_fault_flag), 32'd1);
    ack_step();

    // Random byte stream with random acks, clears and occasional resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (q.size() == 0) gen_frame();
      rxc = ($urandom_range(0, 1) == 1);
      b   = 8'h00;
      if (rxc) b = q.pop_front();
      step(rxc, b, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
           ($urandom_range(0, 599) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
